// File: rtl/lfst_table_if.sv
// ============================================================================
//  Module   : lfst_table_if
//  Purpose  : Rename-group, store-done and dependence-output bundle for lfst_table.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface lfst_table_if #(
    parameter int SSID_W = 7,
    parameter int TAG_W  = 7
);
    logic              stall_in;
    logic              flush_in;
    logic              valid0_in,  valid1_in,  valid2_in,  valid3_in;
    logic              store0_in,  store1_in,  store2_in,  store3_in;
    logic [SSID_W-1:0] ssid0_in,   ssid1_in,   ssid2_in,   ssid3_in;
    logic              ssid_v0_in, ssid_v1_in, ssid_v2_in, ssid_v3_in;
    logic [TAG_W-1:0]  tag0_in,    tag1_in,    tag2_in,    tag3_in;
    logic              st_done_v_in;
    logic [SSID_W-1:0] st_done_ssid_in;
    logic [TAG_W-1:0]  st_done_tag_in;
    logic              dep_v0_out,   dep_v1_out,   dep_v2_out,   dep_v3_out;
    logic [TAG_W-1:0]  dep_tag0_out, dep_tag1_out, dep_tag2_out, dep_tag3_out;

    modport master (
        output stall_in, flush_in,
        output valid0_in, valid1_in, valid2_in, valid3_in,
        output store0_in, store1_in, store2_in, store3_in,
        output ssid0_in, ssid1_in, ssid2_in, ssid3_in,
        output ssid_v0_in, ssid_v1_in, ssid_v2_in, ssid_v3_in,
        output tag0_in, tag1_in, tag2_in, tag3_in,
        output st_done_v_in, st_done_ssid_in, st_done_tag_in,
        input  dep_v0_out, dep_v1_out, dep_v2_out, dep_v3_out,
        input  dep_tag0_out, dep_tag1_out, dep_tag2_out, dep_tag3_out
    );

    modport slave (
        input  stall_in, flush_in,
        input  valid0_in, valid1_in, valid2_in, valid3_in,
        input  store0_in, store1_in, store2_in, store3_in,
        input  ssid0_in, ssid1_in, ssid2_in, ssid3_in,
        input  ssid_v0_in, ssid_v1_in, ssid_v2_in, ssid_v3_in,
        input  tag0_in, tag1_in, tag2_in, tag3_in,
        input  st_done_v_in, st_done_ssid_in, st_done_tag_in,
        output dep_v0_out, dep_v1_out, dep_v2_out, dep_v3_out,
        output dep_tag0_out, dep_tag1_out, dep_tag2_out, dep_tag3_out
    );
endinterface

`default_nettype wire

// File: rtl/lfst_table.sv
// ============================================================================
//  Module   : lfst_table
//  Purpose  : Last Fetched Store Table - 4-lane store-set dependence lookup.
//             Optional macro LFST_INTRAGROUP_BYPASS_EN forwards older same-group stores.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lfst_table #(
    parameter int SSID_W = 7,
    parameter int TAG_W  = 7
) (
    input  wire logic   clock,
    input  wire logic   reset,
    lfst_table_if.slave bus
);
    localparam int ENTRIES = 1 << SSID_W;
    localparam int LANES   = 4;

    logic [LANES-1:0]             w_valid, w_store, w_ssid_v, w_active, w_act_store;
    logic [LANES-1:0][SSID_W-1:0] w_ssid;
    logic [LANES-1:0][TAG_W-1:0]  w_tag;
    logic [LANES-1:0]             w_dep_v;
    logic [LANES-1:0][TAG_W-1:0]  w_dep_tag;
    logic                         w_clr_hit;

    logic [ENTRIES-1:0]             r_ent_v;
    logic [ENTRIES-1:0][TAG_W-1:0]  r_ent_tag;
    logic [LANES-1:0]               r_dep_v;
    logic [LANES-1:0][TAG_W-1:0]    r_dep_tag;

    assign w_valid  = {bus.valid3_in,  bus.valid2_in,  bus.valid1_in,  bus.valid0_in};
    assign w_store  = {bus.store3_in,  bus.store2_in,  bus.store1_in,  bus.store0_in};
    assign w_ssid_v = {bus.ssid_v3_in, bus.ssid_v2_in, bus.ssid_v1_in, bus.ssid_v0_in};
    assign w_ssid   = {bus.ssid3_in,   bus.ssid2_in,   bus.ssid1_in,   bus.ssid0_in};
    assign w_tag    = {bus.tag3_in,    bus.tag2_in,    bus.tag1_in,    bus.tag0_in};

    assign w_active    = w_valid & w_ssid_v;
    assign w_act_store = w_active & w_store;

    assign w_clr_hit = bus.st_done_v_in && r_ent_v[bus.st_done_ssid_in] &&
                       (r_ent_tag[bus.st_done_ssid_in] == bus.st_done_tag_in);

    // Lookup reads the table as it stood before this cycle's writes.
    always_comb begin
        w_dep_v   = '0;
        w_dep_tag = '0;
        for (int k = 0; k < LANES; k++) begin
            if (w_active[k]) begin
                w_dep_v[k]   = r_ent_v[w_ssid[k]];
                w_dep_tag[k] = r_ent_tag[w_ssid[k]];
`ifdef LFST_INTRAGROUP_BYPASS_EN
                // Ascending scan: the youngest older matching store ends up winning.
                for (int j = 0; j < k; j++) begin
                    if (w_act_store[j] && (w_ssid[j] == w_ssid[k])) begin
                        w_dep_v[k]   = 1'b1;
                        w_dep_tag[k] = w_tag[j];
                    end
                end
`endif
            end
        end
    end

    // Clear is issued before rename writes so a same-entry rename write overrides it;
    // later lanes overwrite earlier ones, leaving the youngest store's tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ent_v   <= '0;
            r_ent_tag <= '0;
        end else if (bus.flush_in) begin
            r_ent_v <= '0;
        end else begin
            if (w_clr_hit) begin
                r_ent_v[bus.st_done_ssid_in] <= 1'b0;
            end
            if (!bus.stall_in) begin
                for (int k = 0; k < LANES; k++) begin
                    if (w_act_store[k]) begin
                        r_ent_v[w_ssid[k]]   <= 1'b1;
                        r_ent_tag[w_ssid[k]] <= w_tag[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dep_v   <= '0;
            r_dep_tag <= '0;
        end else if (bus.flush_in) begin
            r_dep_v   <= '0;
            r_dep_tag <= '0;
        end else if (!bus.stall_in) begin
            r_dep_v   <= w_dep_v;
            r_dep_tag <= w_dep_tag;
        end
    end

    assign bus.dep_v0_out   = r_dep_v[0];
    assign bus.dep_v1_out   = r_dep_v[1];
    assign bus.dep_v2_out   = r_dep_v[2];
    assign bus.dep_v3_out   = r_dep_v[3];
    assign bus.dep_tag0_out = r_dep_tag[0];
    assign bus.dep_tag1_out = r_dep_tag[1];
    assign bus.dep_tag2_out = r_dep_tag[2];
    assign bus.dep_tag3_out = r_dep_tag[3];

endmodule

`default_nettype wire

// File: tb/tb_lfst_table.sv
// ============================================================================
//  Module   : tb_lfst_table
//  Purpose  : Scoreboard bench for lfst_table (honours LFST_INTRAGROUP_BYPASS_EN).
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lfst_table;
    localparam int SSID_W = 7;
    localparam int TAG_W  = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfst_table_if #(.SSID_W(SSID_W), .TAG_W(TAG_W)) bus ();

    lfst_table #(.SSID_W(SSID_W), .TAG_W(TAG_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        string            name;
        int               lane;
        logic             v;
        logic [TAG_W-1:0] tag;
        bit               ck_tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic idle_inputs();
        bus.stall_in = 1'b0; bus.flush_in = 1'b0;
        bus.valid0_in = 0; bus.valid1_in = 0; bus.valid2_in = 0; bus.valid3_in = 0;
        bus.store0_in = 0; bus.store1_in = 0; bus.store2_in = 0; bus.store3_in = 0;
        bus.ssid_v0_in = 0; bus.ssid_v1_in = 0; bus.ssid_v2_in = 0; bus.ssid_v3_in = 0;
        bus.ssid0_in = '0; bus.ssid1_in = '0; bus.ssid2_in = '0; bus.ssid3_in = '0;
        bus.tag0_in = '0; bus.tag1_in = '0; bus.tag2_in = '0; bus.tag3_in = '0;
        bus.st_done_v_in = 1'b0; bus.st_done_ssid_in = '0; bus.st_done_tag_in = '0;
    endtask

    task automatic set_lane(input int k, input logic v, input logic st,
                            input logic [SSID_W-1:0] ssid, input logic sv,
                            input logic [TAG_W-1:0] tag);
        case (k)
            0: begin bus.valid0_in = v; bus.store0_in = st; bus.ssid0_in = ssid; bus.ssid_v0_in = sv; bus.tag0_in = tag; end
            1: begin bus.valid1_in = v; bus.store1_in = st; bus.ssid1_in = ssid; bus.ssid_v1_in = sv; bus.tag1_in = tag; end
            2: begin bus.valid2_in = v; bus.store2_in = st; bus.ssid2_in = ssid; bus.ssid_v2_in = sv; bus.tag2_in = tag; end
            default: begin bus.valid3_in = v; bus.store3_in = st; bus.ssid3_in = ssid; bus.ssid_v3_in = sv; bus.tag3_in = tag; end
        endcase
    endtask

    task automatic expect_lane(input string n, input int k, input logic v,
                               input logic [TAG_W-1:0] t, input bit ct);
        exp_t e;
        e.name = n; e.lane = k; e.v = v; e.tag = t; e.ck_tag = ct;
        sb.push_back(e);
    endtask

    function automatic logic get_v(input int k);
        case (k)
            0: return bus.dep_v0_out;
            1: return bus.dep_v1_out;
            2: return bus.dep_v2_out;
            default: return bus.dep_v3_out;
        endcase
    endfunction

    function automatic logic [TAG_W-1:0] get_t(input int k);
        case (k)
            0: return bus.dep_tag0_out;
            1: return bus.dep_tag1_out;
            2: return bus.dep_tag2_out;
            default: return bus.dep_tag3_out;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            idle_inputs();
            case (s)
                0: begin
                    rst = 1'b1;
                    for (int k = 0; k < 4; k++) expect_lane("reset_state", k, 1'b0, '0, 1'b1);
                end
                default: begin
                    rst = 1'b0;
                    set_lane(0, 1, 0, 7'd5, 1, 7'h00);
                    set_lane(1, 1, 1, 7'd9, 0, 7'h05);
                    expect_lane("first_load_empty", 0, 1'b0, 7'h00, 1'b1);
                    expect_lane("ssid_invalid_lane", 1, 1'b0, 7'h00, 1'b1);
                end
            endcase
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (get_v(e.lane) !== e.v || (e.ck_tag && get_t(e.lane) !== e.tag)) begin
                    failures++;
                    $display("FAIL %s lane%0d: got v=%0b tag=0x%02h, expected v=%0b tag=0x%02h",
                             e.name, e.lane, get_v(e.lane), get_t(e.lane), e.v, e.tag);
                end
            end
        end
    endtask

    task automatic test_store_load();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            idle_inputs();
            case (s)
                0: begin
                    set_lane(0, 1, 1, 7'd5, 1, 7'h12);
                    expect_lane("store_lookup_empty", 0, 1'b0, 7'h00, 1'b1);
                end
                default: begin
                    set_lane(0, 1, 0, 7'd5, 0, 7'h00);
                    set_lane(1, 1, 0, 7'd5, 1, 7'h00);
                    expect_lane("inactive_lane_zero", 0, 1'b0, 7'h00, 1'b1);
                    expect_lane("load_after_store", 1, 1'b1, 7'h12, 1'b1);
                end
            endcase
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (get_v(e.lane) !== e.v || (e.ck_tag && get_t(e.lane) !== e.tag)) begin
                    failures++;
                    $display("FAIL %s lane%0d: got v=%0b tag=0x%02h, expected v=%0b tag=0x%02h",
                             e.name, e.lane, get_v(e.lane), get_t(e.lane), e.v, e.tag);
                end
            end
        end
    endtask

    task automatic test_st_done();
        exp_t e;
        for (int s = 0; s < 5; s++) begin
            idle_inputs();
            case (s)
                0: begin
                    bus.st_done_v_in = 1; bus.st_done_ssid_in = 7'd5; bus.st_done_tag_in = 7'h11;
                    expect_lane("idle_group", 0, 1'b0, 7'h00, 1'b1);
                end
                1: begin
                    bus.st_done_v_in = 1; bus.st_done_ssid_in = 7'd5; bus.st_done_tag_in = 7'h12;
                    set_lane(0, 1, 0, 7'd5, 1, 7'h00);
                    expect_lane("clr_tag_mismatch_kept", 0, 1'b1, 7'h12, 1'b1);
                end
                2: begin
                    set_lane(0, 1, 0, 7'd5, 1, 7'h00);
                    set_lane(1, 1, 1, 7'd5, 1, 7'h12);
                    expect_lane("clr_tag_match", 0, 1'b0, 7'h00, 1'b0);
                    expect_lane("clr_store_lookup", 1, 1'b0, 7'h00, 1'b0);
                end
                3: begin
                    bus.st_done_v_in = 1; bus.st_done_ssid_in = 7'd5; bus.st_done_tag_in = 7'h12;
                    set_lane(0, 1, 1, 7'd5, 1, 7'h30);
                    expect_lane("clr_vs_write_lookup", 0, 1'b1, 7'h12, 1'b1);
                end
                default: begin
                    set_lane(2, 1, 0, 7'd5, 1, 7'h00);
                    expect_lane("write_beats_clear", 2, 1'b1, 7'h30, 1'b1);
                end
            endcase
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (get_v(e.lane) !== e.v || (e.ck_tag && get_t(e.lane) !== e.tag)) begin
                    failures++;
                    $display("FAIL %s lane%0d: got v=%0b tag=0x%02h, expected v=%0b tag=0x%02h",
                             e.name, e.lane, get_v(e.lane), get_t(e.lane), e.v, e.tag);
                end
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            idle_inputs();
            case (s)
                0: begin
                    set_lane(0, 1, 1, 7'd3, 1, 7'h20);
                    set_lane(1, 1, 1, 7'd3, 1, 7'h21);
                    set_lane(3, 1, 0, 7'd3, 1, 7'h00);
                    expect_lane("grp_lane0", 0, 1'b0, 7'h00, 1'b0);
                    expect_lane("grp_lane2_idle", 2, 1'b0, 7'h00, 1'b1);
`ifdef LFST_INTRAGROUP_BYPASS_EN
                    expect_lane("bypass_lane1", 1, 1'b1, 7'h20, 1'b1);
                    expect_lane("bypass_lane3", 3, 1'b1, 7'h21, 1'b1);
`else
                    expect_lane("nobypass_lane1", 1, 1'b0, 7'h00, 1'b0);
                    expect_lane("nobypass_lane3", 3, 1'b0, 7'h00, 1'b0);
`endif
                end
                default: begin
                    set_lane(0, 1, 0, 7'd3, 1, 7'h00);
                    expect_lane("youngest_write", 0, 1'b1, 7'h21, 1'b1);
                end
            endcase
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (get_v(e.lane) !== e.v || (e.ck_tag && get_t(e.lane) !== e.tag)) begin
                    failures++;
                    $display("FAIL %s lane%0d: got v=%0b tag=0x%02h, expected v=%0b tag=0x%02h",
                             e.name, e.lane, get_v(e.lane), get_t(e.lane), e.v, e.tag);
                end
            end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        for (int s = 0; s < 8; s++) begin
            idle_inputs();
            case (s)
                0, 1: for (int k = 0; k < 4; k++) begin
                    set_lane(k, 1, 1, SSID_W'(20 + 4*s + k), 1, TAG_W'(8'h40 + 4*s + k));
                    expect_lane("fill_lookup", k, 1'b0, 7'h00, 1'b0);
                end
                2: for (int k = 0; k < 2; k++) begin
                    set_lane(k, 1, 1, SSID_W'(28 + k), 1, TAG_W'(8'h48 + k));
                    expect_lane("fill_lookup", k, 1'b0, 7'h00, 1'b0);
                end
                3: for (int k = 0; k < 4; k++) begin
                    set_lane(k, 1, 0, SSID_W'(20 + k), 1, 7'h00);
                    expect_lane("filled_hit", k, 1'b1, TAG_W'(8'h40 + k), 1'b1);
                end
                4: begin
                    bus.flush_in = 1; bus.stall_in = 1;
                    set_lane(0, 1, 1, 7'd40, 1, 7'h01);
                    for (int k = 1; k < 4; k++) set_lane(k, 1, 0, SSID_W'(23 + k), 1, 7'h00);
                    for (int k = 0; k < 4; k++) expect_lane("flush_outputs", k, 1'b0, 7'h00, 1'b0);
                end
                5, 6: for (int k = 0; k < 4; k++) begin
                    set_lane(k, 1, 0, SSID_W'(20 + 4*(s-5) + k), 1, 7'h00);
                    expect_lane("after_flush", k, 1'b0, 7'h00, 1'b0);
                end
                default: begin
                    set_lane(0, 1, 0, 7'd28, 1, 7'h00);
                    set_lane(1, 1, 0, 7'd29, 1, 7'h00);
                    set_lane(2, 1, 0, 7'd40, 1, 7'h00);
                    for (int k = 0; k < 3; k++) expect_lane("after_flush_tail", k, 1'b0, 7'h00, 1'b0);
                end
            endcase
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (get_v(e.lane) !== e.v || (e.ck_tag && get_t(e.lane) !== e.tag)) begin
                    failures++;
                    $display("FAIL %s lane%0d: got v=%0b tag=0x%02h, expected v=%0b tag=0x%02h",
                             e.name, e.lane, get_v(e.lane), get_t(e.lane), e.v, e.tag);
                end
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int s = 0; s < 6; s++) begin
            idle_inputs();
            case (s)
                0: begin
                    set_lane(0, 1, 1, 7'd50, 1, 7'h55);
                    expect_lane("stall_setup", 0, 1'b0, 7'h00, 1'b0);
                end
                1: begin
                    set_lane(0, 1, 0, 7'd50, 1, 7'h00);
                    set_lane(2, 1, 0, 7'd60, 1, 7'h00);
                    expect_lane("pre_stall_hit", 0, 1'b1, 7'h55, 1'b1);
                    expect_lane("pre_stall_miss", 2, 1'b0, 7'h00, 1'b0);
                end
                2, 3, 4: begin
                    bus.stall_in = 1;
                    set_lane(0, 1, 1, 7'd50, 1, TAG_W'(8'h66 + s));
                    set_lane(1, 1, 0, 7'd50, 1, 7'h00);
                    set_lane(3, 1, 1, 7'd61, 1, TAG_W'(s));
                    expect_lane("stall_hold0", 0, 1'b1, 7'h55, 1'b1);
                    expect_lane("stall_hold1", 1, 1'b0, 7'h00, 1'b1);
                    expect_lane("stall_hold2", 2, 1'b0, 7'h00, 1'b0);
                    expect_lane("stall_hold3", 3, 1'b0, 7'h00, 1'b1);
                end
                default: begin
                    set_lane(0, 1, 0, 7'd50, 1, 7'h00);
                    set_lane(1, 1, 0, 7'd61, 1, 7'h00);
                    expect_lane("table_unchanged", 0, 1'b1, 7'h55, 1'b1);
                    expect_lane("stalled_store_dropped", 1, 1'b0, 7'h00, 1'b0);
                end
            endcase
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (get_v(e.lane) !== e.v || (e.ck_tag && get_t(e.lane) !== e.tag)) begin
                    failures++;
                    $display("FAIL %s lane%0d: got v=%0b tag=0x%02h, expected v=%0b tag=0x%02h",
                             e.name, e.lane, get_v(e.lane), get_t(e.lane), e.v, e.tag);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            idle_inputs();
            case (s)
                0: begin
                    bus.stall_in = 1;
                    set_lane(0, 1, 1, 7'd50, 1, 7'h77);
                    expect_lane("stall_before_reset", 0, 1'b1, 7'h55, 1'b1);
                end
                1: begin
                    bus.stall_in = 1;
                    set_lane(0, 1, 1, 7'd50, 1, 7'h78);
                    for (int k = 0; k < 4; k++) expect_lane("async_reset", k, 1'b0, 7'h00, 1'b1);
                end
                2: begin
                    set_lane(0, 1, 1, 7'd71, 1, 7'h12);
                    for (int k = 0; k < 4; k++) expect_lane("reset_held", k, 1'b0, 7'h00, 1'b1);
                end
                default: begin
                    rst = 1'b0;
                    set_lane(0, 1, 0, 7'd50, 1, 7'h00);
                    set_lane(1, 1, 0, 7'd71, 1, 7'h00);
                    set_lane(2, 1, 0, 7'd5, 1, 7'h00);
                    set_lane(3, 1, 0, 7'd3, 1, 7'h00);
                    for (int k = 0; k < 4; k++) expect_lane("empty_after_reset", k, 1'b0, 7'h00, 1'b0);
                end
            endcase
            if (s == 1) begin
                #3 rst = 1'b1;
                #1;
            end else begin
                tick();
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (get_v(e.lane) !== e.v || (e.ck_tag && get_t(e.lane) !== e.tag)) begin
                    failures++;
                    $display("FAIL %s lane%0d: got v=%0b tag=0x%02h, expected v=%0b tag=0x%02h",
                             e.name, e.lane, get_v(e.lane), get_t(e.lane), e.v, e.tag);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_store_load();
        test_st_done();
        test_bypass();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
